// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer for the E stage: runs one op for a fixed
// latency, commits to HI/LO, and serves mthi/mtlo. Optional madd/msub family via `MD_MADD_EN.
module md_sequencer #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             op_ok_c;
  logic             accept_c;
  logic [CNT_W-1:0] lat_c;

  logic [63:0]      a_sx_c, b_sx_c;
  logic [63:0]      prod_s_c, prod_u_c;
  logic [31:0]      a_mag_c, b_mag_c, divisor_c;
  logic [31:0]      q_mag_c, r_mag_c;
  logic [31:0]      q_s_c, r_s_c;
  logic [31:0]      divisor_u_c, q_u_c, r_u_c;
  logic [63:0]      acc_c;
  logic [63:0]      res_c;
  logic             res_we_c;

`ifdef MD_MADD_EN
  assign op_ok_c = 1'b1;
`else
  assign op_ok_c = ~op[2];
`endif

  assign accept_c = (state_q == S_IDLE) && start && !flush && op_ok_c;
  assign lat_c    = (op[2:1] == 2'b01) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

  // Datapath on the latched operands; only sampled in the commit cycle.
  always_comb begin
    a_sx_c   = {{32{a_q[31]}}, a_q};
    b_sx_c   = {{32{b_q[31]}}, b_q};
    prod_s_c = a_sx_c * b_sx_c;
    prod_u_c = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide via magnitudes; 0x80000000/-1 falls out as q=0x80000000, r=0.
    a_mag_c   = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag_c   = b_q[31] ? (32'd0 - b_q) : b_q;
    divisor_c = (b_mag_c == 32'd0) ? 32'd1 : b_mag_c;
    q_mag_c   = a_mag_c / divisor_c;
    r_mag_c   = a_mag_c % divisor_c;
    q_s_c     = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag_c) : q_mag_c;
    r_s_c     = a_q[31] ? (32'd0 - r_mag_c) : r_mag_c;

    divisor_u_c = (b_q == 32'd0) ? 32'd1 : b_q;
    q_u_c       = a_q / divisor_u_c;
    r_u_c       = a_q % divisor_u_c;

    acc_c = {hi_q, lo_q};
  end

  // Result select; divide by zero leaves HI/LO untouched.
  always_comb begin
    res_c    = 64'd0;
    res_we_c = 1'b0;
    case (op_q)
      OP_MULT: begin
        res_c    = prod_s_c;
        res_we_c = 1'b1;
      end
      OP_MULTU: begin
        res_c    = prod_u_c;
        res_we_c = 1'b1;
      end
      OP_DIV: begin
        res_c    = {r_s_c, q_s_c};
        res_we_c = (b_q != 32'd0);
      end
      OP_DIVU: begin
        res_c    = {r_u_c, q_u_c};
        res_we_c = (b_q != 32'd0);
      end
`ifdef MD_MADD_EN
      OP_MADD: begin
        res_c    = acc_c + prod_s_c;
        res_we_c = 1'b1;
      end
      OP_MADDU: begin
        res_c    = acc_c + prod_u_c;
        res_we_c = 1'b1;
      end
      OP_MSUB: begin
        res_c    = acc_c - prod_s_c;
        res_we_c = 1'b1;
      end
      OP_MSUBU: begin
        res_c    = acc_c - prod_u_c;
        res_we_c = 1'b1;
      end
`else
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        res_c    = acc_c;
        res_we_c = 1'b0;
      end
`endif
      default: begin
        res_c    = 64'd0;
        res_we_c = 1'b0;
      end
    endcase
  end

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_we && !flush) hi_d = wdata;
        if (lo_we && !flush) lo_d = wdata;
        if (accept_c) begin
          state_d = S_RUN;
          cnt_d   = lat_c;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          done_d  = (lat_c == CNT_W'(1));
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          if (res_we_c) begin
            hi_d = res_c[63:32];
            lo_d = res_c[31:0];
          end
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          done_d = (cnt_q == CNT_W'(2));
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency/done timing, mult/div results,
// divide-by-zero, overflow, flush, register writes, reset and madd option.
module tb_md_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fails  = 0;

  md_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch an op this cycle and check busy/done across its full latency.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int lat);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    for (int k = 1; k <= lat; k++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(done), (k == lat) ? 32'd1 : 32'd0);
      tick();
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    hi_we = 1'b1;
    wdata = h;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = l;
    tick();
    lo_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'h0;
    b     = 32'h0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'h0;
    flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);

    // mult -2 * 3 = -6
    run_op("mult", 3'b000, 32'hFFFF_FFFE, 32'd3, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFF * 2
    run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'd2, 5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2 = -3 rem -1
    run_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    // divu by zero leaves HI/LO alone
    write_hilo(32'h1234, 32'h1234);
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h1234);
    run_op("divz", 3'b011, 32'd9, 32'd0, 10);
    chk("divz_hi", hi, 32'h1234);
    chk("divz_lo", lo, 32'h1234);

    // divu 100 / 7 = 14 rem 2
    run_op("divu", 3'b011, 32'd100, 32'd7, 10);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);

    // signed overflow case
    run_op("dovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("dovf_hi", hi, 32'h0);
    chk("dovf_lo", lo, 32'h8000_0000);

    // flush in 3rd busy cycle: no commit, then mtlo works
    start = 1'b1;
    op    = 3'b000;
    a     = 32'd5;
    b     = 32'd7;
    tick();
    start = 1'b0;
    tick();
    chk("fl_busy2", 32'(busy), 32'd1);
    tick();
    chk("fl_busy3", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_done", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("fl_hi", hi, 32'h0);
    chk("fl_lo", lo, 32'h8000_0000);
    lo_we = 1'b1;
    wdata = 32'hAAAA;
    tick();
    lo_we = 1'b0;
    chk("fl_mtlo", lo, 32'hAAAA);

    // start together with flush in IDLE is dropped
    start = 1'b1;
    flush = 1'b1;
    op    = 3'b001;
    a     = 32'd3;
    b     = 32'd3;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("sfl_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("sfl_lo", lo, 32'hAAAA);

    // start with mtlo in the same cycle; mthi during busy ignored
    start = 1'b1;
    op    = 3'b000;
    a     = 32'd2;
    b     = 32'd3;
    lo_we = 1'b1;
    wdata = 32'h5555;
    tick();
    start = 1'b0;
    lo_we = 1'b0;
    chk("sw_lo_first", lo, 32'h5555);
    chk("sw_busy", 32'(busy), 32'd1);
    hi_we = 1'b1;
    wdata = 32'hDEAD;
    tick();
    hi_we = 1'b0;
    chk("sw_hi_ignored", hi, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    chk("sw_busy_end", 32'(busy), 32'd0);
    chk("sw_hi", hi, 32'h0);
    chk("sw_lo", lo, 32'd6);

    // reset mid-operation
    write_hilo(32'h77, 32'h88);
    start = 1'b1;
    op    = 3'b010;
    a     = 32'd50;
    b     = 32'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_hi", hi, 32'h0);
    chk("mrst_lo", lo, 32'h0);
    for (int k = 0; k < 10; k++) tick();
    chk("mrst_lo_late", lo, 32'h0);

    // maddu accumulate (or no-op when the option is off)
    write_hilo(32'h0, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
    run_op("maddu", 3'b101, 32'd1, 32'd1, 5);
    chk("maddu_hi", hi, 32'h1);
    chk("maddu_lo", lo, 32'h0);
    run_op("msub", 3'b110, 32'd2, 32'hFFFF_FFFF, 5);
    chk("msub_hi", hi, 32'h1);
    chk("msub_lo", lo, 32'h2);
`else
    start = 1'b1;
    op    = 3'b101;
    a     = 32'd1;
    b     = 32'd1;
    tick();
    start = 1'b0;
    chk("maddu_off_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 6; k++) tick();
    chk("maddu_off_busy2", 32'(busy), 32'd0);
    chk("maddu_off_hi", hi, 32'h0);
    chk("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
